// File: rtl/sdram_bridge_pkg.sv
// Shared types and AXI encodings for the AXI4-to-APB bridge in front of the SDRAM controller.
package sdram_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_SETUP,
        S_ACCESS,
        S_RD_RESP,
        S_WR_RESP
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sdram_axi_addr_gen.sv
// Combinational AXI4 next-beat address: FIXED, INCR and WRAP; reserved burst behaves as INCR.
module sdram_axi_addr_gen
    import sdram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [1:0]        w_shift;
    logic [ADDR_W-1:0] w_bsize;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_mask;

    // The data bus is 32 bits, so anything wider than a word is clamped to a word.
    assign w_shift = (i_size > 3'd2) ? 2'd2 : i_size[1:0];
    assign w_bsize = ADDR_W'(1) << w_shift;
    assign w_incr  = i_addr + w_bsize;
    assign w_mask  = ((ADDR_W'(i_len) + ADDR_W'(1)) << w_shift) - ADDR_W'(1);

    always_comb begin
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
            default:     o_next_addr = w_incr;
        endcase
    end

endmodule

// File: rtl/sdram_axi_apb_bridge.sv
// AXI4 slave to APB master bridge: one burst in flight, each beat becomes one unbuffered APB transfer.
module sdram_axi_apb_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_awvalid,
    output logic              in_awready,
    input  logic [ADDR_W-1:0] in_awaddr,
    input  logic [ID_W-1:0]   in_awid,
    input  logic [7:0]        in_awlen,
    input  logic [2:0]        in_awsize,
    input  logic [1:0]        in_awburst,
    input  logic              in_wvalid,
    output logic              in_wready,
    input  logic [31:0]       in_wdata,
    input  logic [3:0]        in_wstrb,
    input  logic              in_wlast,
    output logic              in_bvalid,
    input  logic              in_bready,
    output logic [ID_W-1:0]   in_bid,
    output logic [1:0]        in_bresp,
    input  logic              in_arvalid,
    output logic              in_arready,
    input  logic [ADDR_W-1:0] in_araddr,
    input  logic [ID_W-1:0]   in_arid,
    input  logic [7:0]        in_arlen,
    input  logic [2:0]        in_arsize,
    input  logic [1:0]        in_arburst,
    output logic              in_rvalid,
    input  logic              in_rready,
    output logic [31:0]       in_rdata,
    output logic [1:0]        in_rresp,
    output logic              in_rlast,
    output logic [ID_W-1:0]   in_rid,
    output logic              out_psel,
    output logic              out_penable,
    output logic              out_pwrite,
    output logic [ADDR_W-1:0] out_paddr,
    output logic [2:0]        out_pprot,
    output logic [31:0]       out_pwdata,
    output logic [3:0]        out_pstrb,
    input  logic              out_pready,
    input  logic              out_pslverr,
    input  logic [31:0]       out_prdata
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len, r_beat;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_write, r_err, r_rd_prio;
    logic [31:0]       r_pwdata, r_rdata;
    logic [3:0]        r_pstrb;
    logic [1:0]        r_rresp;

    logic [ADDR_W-1:0] w_next_addr;
    logic              w_grant_rd, w_grant_wr, w_contend, w_last;
    logic              w_unused;

    // Burst length comes from the counter alone; wlast carries no information here.
    assign w_unused = in_wlast;
    assign w_last   = (r_beat == r_len);

    sdram_axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    // Round-robin flag only moves when both channels contend, so an uncontended grant keeps priority.
    assign w_contend  = (r_state == S_IDLE) && !reset && in_arvalid && in_awvalid;
    assign w_grant_rd = (r_state == S_IDLE) && !reset && in_arvalid && (!in_awvalid || r_rd_prio);
    assign w_grant_wr = (r_state == S_IDLE) && !reset && in_awvalid && (!in_arvalid || !r_rd_prio);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_arready  = 1'b0;
        in_awready  = 1'b0;
        in_wready   = 1'b0;
        in_rvalid   = 1'b0;
        in_bvalid   = 1'b0;
        out_psel    = 1'b0;
        out_penable = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_arready = w_grant_rd;
                in_awready = w_grant_wr;
                if (w_grant_rd)      w_state_nxt = S_SETUP;
                else if (w_grant_wr) w_state_nxt = S_WR_DATA;
            end
            S_WR_DATA: begin
                in_wready = 1'b1;
                if (in_wvalid) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                out_psel    = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                out_psel    = 1'b1;
                out_penable = 1'b1;
                if (out_pready) begin
                    if (!r_write)    w_state_nxt = S_RD_RESP;
                    else if (w_last) w_state_nxt = S_WR_RESP;
                    else             w_state_nxt = S_WR_DATA;
                end
            end
            S_RD_RESP: begin
                in_rvalid = 1'b1;
                if (in_rready) w_state_nxt = w_last ? S_IDLE : S_SETUP;
            end
            S_WR_RESP: begin
                in_bvalid = 1'b1;
                if (in_bready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_prio <= 1'b1;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_contend) r_rd_prio <= !r_rd_prio;
            if (w_grant_rd) begin
                r_addr  <= in_araddr;
                r_id    <= in_arid;
                r_len   <= in_arlen;
                r_size  <= in_arsize;
                r_burst <= in_arburst;
                r_beat  <= '0;
                r_err   <= 1'b0;
                r_write <= 1'b0;
            end else if (w_grant_wr) begin
                r_addr  <= in_awaddr;
                r_id    <= in_awid;
                r_len   <= in_awlen;
                r_size  <= in_awsize;
                r_burst <= in_awburst;
                r_beat  <= '0;
                r_err   <= 1'b0;
                r_write <= 1'b1;
            end
            if (r_state == S_WR_DATA && in_wvalid) begin
                r_pwdata <= in_wdata;
                r_pstrb  <= in_wstrb;
            end
            if (r_state == S_ACCESS && out_pready) begin
                if (!r_write) begin
                    r_rdata <= out_prdata;
                    r_rresp <= out_pslverr ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    r_err <= r_err | out_pslverr;
                    if (!w_last) begin
                        r_beat <= r_beat + 8'd1;
                        r_addr <= w_next_addr;
                    end
                end
            end
            if (r_state == S_RD_RESP && in_rready && !w_last) begin
                r_beat <= r_beat + 8'd1;
                r_addr <= w_next_addr;
            end
        end
    end

    assign in_rdata    = r_rdata;
    assign in_rresp    = r_rresp;
    assign in_rlast    = (r_state == S_RD_RESP) && w_last;
    assign in_rid      = r_id;
    assign in_bid      = r_id;
    assign in_bresp    = r_err ? RESP_SLVERR : RESP_OKAY;
    assign out_pwrite  = r_write;
    assign out_paddr   = r_addr;
    assign out_pprot   = 3'b000;
    assign out_pwdata  = r_pwdata;
    assign out_pstrb   = r_pstrb;

endmodule
